axis_blend_window_ctl: RTL and testbench

Frame-synchronous controller placed on the s0 (background) path in front of `axis_blender`. It tracks row and column of every s0 beat and latches the overlay window geometry once per frame. It marks each beat with the "inside overlay" need bit the blender consumes, and drives the blender's `s1_enable` so that s1 is pulled only while a valid window exists for the current frame.

---
 rtl/axis_blend_window_ctl_pkg.sv | 14 +
 rtl/axis_blend_window_ctl_if.sv | 14 +
 rtl/axis_blend_window_ctl_skid_buf.sv | 64 ++++++
 rtl/axis_blend_window_ctl.sv | 175 +++++++++++++++++
 tb/tb_axis_blend_window_ctl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_blend_window_ctl_pkg.sv
// Shared definitions for the blend window controller and the downstream blender:
// frame FSM encoding and the meaning of each tuser bit on the s0 path.
package axis_blend_window_ctl_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    localparam int TUSER_SOF  = 0;
    localparam int TUSER_NEED = 1;
    localparam int TUSER_W    = 2;

endpackage

// File: rtl/axis_blend_window_ctl_if.sv
// AXI4-Stream bundle used on both sides of the window controller.
interface axis_blend_window_ctl_if #(
    parameter int DATA_W = 8,
    parameter int USER_W = 1
) ();
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_blend_window_ctl_skid_buf.sv
// Two-entry AXIS skid buffer: registered ready, one-cycle latency, full throughput.
// Output payload is held stable while valid is not yet taken.
module axis_skid_buf #(
    parameter int DATA_W = 8,
    parameter int USER_W = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [USER_W-1:0] in_user,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [USER_W-1:0] out_user,
    output logic              out_last
);
    localparam int W = DATA_W + USER_W + 1;

    logic [W-1:0] in_payload;
    logic [W-1:0] out_reg;
    logic [W-1:0] skid_reg;
    logic         out_valid_reg;
    logic         skid_valid_reg;
    logic         in_ready_reg;

    assign in_payload = {in_last, in_user, in_data};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b0;
        end else if (!skid_valid_reg) begin
            in_ready_reg <= 1'b1;
            if (in_valid && in_ready_reg) begin
                if (!out_valid_reg || out_ready) begin
                    out_reg       <= in_payload;
                    out_valid_reg <= 1'b1;
                end else begin
                    // Output is blocked: park the beat and close the input.
                    skid_reg       <= in_payload;
                    skid_valid_reg <= 1'b1;
                    in_ready_reg   <= 1'b0;
                end
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end else if (out_ready) begin
            out_reg        <= skid_reg;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end
    end

    assign in_ready                         = in_ready_reg;
    assign out_valid                        = out_valid_reg;
    assign {out_last, out_user, out_data}   = out_reg;

endmodule

// File: rtl/axis_blend_window_ctl.sv
// s0-path controller for axis_blender: tracks row/col per beat, latches window geometry
// at SOF, tags each beat with the inside-window bit and gates the blender's s1 pull.
module axis_blend_window_ctl
    import axis_blend_window_ctl_pkg::*;
#(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_IMG_BITS   = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [C_IMG_BITS-1:0] img_width,
    input  logic [C_IMG_BITS-1:0] img_height,
    input  logic                  win_en,
    input  logic [C_IMG_BITS-1:0] win_left,
    input  logic [C_IMG_BITS-1:0] win_top,
    input  logic [C_IMG_BITS-1:0] win_width,
    input  logic [C_IMG_BITS-1:0] win_height,
    axis_blend_window_ctl_if.slave  s_axis,
    axis_blend_window_ctl_if.master m_axis,
    output logic                  s1_enable,
    output logic                  frame_done,
    output logic                  err_sof,
    output logic                  err_line
);
    localparam logic [C_IMG_BITS-1:0] ONE = {{(C_IMG_BITS-1){1'b0}}, 1'b1};

    state_t                state_reg, state_next;
    logic [C_IMG_BITS-1:0] row_reg, row_next;
    logic [C_IMG_BITS-1:0] col_reg, col_next;
    logic [C_IMG_BITS-1:0] img_w_reg, img_h_reg;
    logic [C_IMG_BITS-1:0] left_reg, top_reg, width_reg, height_reg;
    logic                  win_en_reg;
    logic                  s1_hold_reg;

    logic                  buf_ready, in_fire, is_sof, fwd;
    logic                  need, beat_s1, last_col, last_row, eof;
    logic [TUSER_W-1:0]    beat_user;
    logic                  eff_win_en;
    logic [C_IMG_BITS-1:0] eff_img_w, eff_img_h, eff_left, eff_top, eff_width, eff_height;
    logic [C_IMG_BITS-1:0] eff_row, eff_col;

    logic [C_IMG_BITS-1:0] span_pos   [2];
    logic [C_IMG_BITS-1:0] span_start [2];
    logic [C_IMG_BITS-1:0] span_len   [2];
    logic [1:0]            in_span;

    logic                    out_valid, out_last, out_s1, out_eof;
    logic [TUSER_W-1:0]      out_user;
    logic [C_DATA_WIDTH-1:0] out_pixel;
    logic [C_DATA_WIDTH+1:0] out_data;

    assign in_fire = s_axis.tvalid && buf_ready;
    assign is_sof  = s_axis.tuser[TUSER_SOF];
    assign fwd     = in_fire && (state_reg == IN_FRAME || is_sof);

    // A SOF beat is classified with the config it is latching, at position 0,0.
    assign eff_win_en = is_sof ? win_en     : win_en_reg;
    assign eff_img_w  = is_sof ? img_width  : img_w_reg;
    assign eff_img_h  = is_sof ? img_height : img_h_reg;
    assign eff_left   = is_sof ? win_left   : left_reg;
    assign eff_top    = is_sof ? win_top    : top_reg;
    assign eff_width  = is_sof ? win_width  : width_reg;
    assign eff_height = is_sof ? win_height : height_reg;
    assign eff_row    = is_sof ? '0 : row_reg;
    assign eff_col    = is_sof ? '0 : col_reg;

    assign span_pos[0]   = eff_col;
    assign span_start[0] = eff_left;
    assign span_len[0]   = eff_width;
    assign span_pos[1]   = eff_row;
    assign span_start[1] = eff_top;
    assign span_len[1]   = eff_height;

    // Window end is one bit wider so a window hanging off the image never wraps.
    for (genvar gi = 0; gi < 2; gi++) begin : g_span
        logic [C_IMG_BITS:0] span_stop;
        assign span_stop   = {1'b0, span_start[gi]} + {1'b0, span_len[gi]};
        assign in_span[gi] = (span_pos[gi] >= span_start[gi]) &&
                             ({1'b0, span_pos[gi]} < span_stop);
    end

    assign need     = eff_win_en && (&in_span);
    assign beat_s1  = eff_win_en && (eff_width != '0) && (eff_height != '0);
    assign last_col = (eff_col == eff_img_w - ONE);
    assign last_row = (eff_row == eff_img_h - ONE);
    assign eof      = s_axis.tlast && last_row;

    always_comb begin
        beat_user             = '0;
        beat_user[TUSER_SOF]  = is_sof;
        beat_user[TUSER_NEED] = need;
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        if (fwd) begin
            if (s_axis.tlast) begin
                col_next = '0;
                row_next = eff_row + ONE;
            end else begin
                col_next = eff_col + ONE;
                row_next = eff_row;
            end
            state_next = eof ? WAIT_SOF : IN_FRAME;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= WAIT_SOF;
            row_reg     <= '0;
            col_reg     <= '0;
            img_w_reg   <= '0;
            img_h_reg   <= '0;
            left_reg    <= '0;
            top_reg     <= '0;
            width_reg   <= '0;
            height_reg  <= '0;
            win_en_reg  <= 1'b0;
            s1_hold_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            if (in_fire && is_sof) begin
                img_w_reg  <= img_width;
                img_h_reg  <= img_height;
                left_reg   <= win_left;
                top_reg    <= win_top;
                width_reg  <= win_width;
                height_reg <= win_height;
                win_en_reg <= win_en;
            end
            if (out_valid && m_axis.tready && out_user[TUSER_SOF])
                s1_hold_reg <= out_s1;
        end
    end

    // s1 gate and end-of-frame marker ride alongside the pixel through the buffer.
    axis_skid_buf #(
        .DATA_W (C_DATA_WIDTH + 2),
        .USER_W (TUSER_W)
    ) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (s_axis.tvalid && (state_reg == IN_FRAME || is_sof)),
        .in_ready  (buf_ready),
        .in_data   ({beat_s1, eof, s_axis.tdata}),
        .in_user   (beat_user),
        .in_last   (s_axis.tlast),
        .out_valid (out_valid),
        .out_ready (m_axis.tready),
        .out_data  (out_data),
        .out_user  (out_user),
        .out_last  (out_last)
    );

    assign out_pixel = out_data[C_DATA_WIDTH-1:0];
    assign out_eof   = out_data[C_DATA_WIDTH];
    assign out_s1    = out_data[C_DATA_WIDTH+1];

    assign s_axis.tready = buf_ready;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_pixel;
    assign m_axis.tuser  = out_user;
    assign m_axis.tlast  = out_last;

    assign s1_enable  = (out_valid && out_user[TUSER_SOF]) ? out_s1 : s1_hold_reg;
    assign frame_done = out_valid && m_axis.tready && out_eof;
    assign err_sof    = in_fire && (state_reg == IN_FRAME) && is_sof;
    assign err_line   = fwd && (s_axis.tlast != last_col);

endmodule

// File: tb/tb_axis_blend_window_ctl.sv
// Directed bench for axis_blend_window_ctl: frames of row*16+col pixels, expected
// beats built from the bench's own SOF-latched window model.
module tb_axis_blend_window_ctl;
    import axis_blend_window_ctl_pkg::*;

    logic        clk;
    logic        resetn;
    logic [11:0] img_width, img_height, win_left, win_top, win_width, win_height;
    logic        win_en;
    logic        s1_enable, frame_done, err_sof, err_line;

    axis_blend_window_ctl_if #(.DATA_W(8), .USER_W(1))       s_if ();
    axis_blend_window_ctl_if #(.DATA_W(8), .USER_W(TUSER_W)) m_if ();

    axis_blend_window_ctl #(.C_DATA_WIDTH(8), .C_IMG_BITS(12)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .img_width  (img_width),
        .img_height (img_height),
        .win_en     (win_en),
        .win_left   (win_left),
        .win_top    (win_top),
        .win_width  (win_width),
        .win_height (win_height),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .s1_enable  (s1_enable),
        .frame_done (frame_done),
        .err_sof    (err_sof),
        .err_line   (err_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit rnd_valid  = 0;

    logic [11:0] exp_q[$];
    logic [11:0] out_q[$];
    int fd_q[$], esof_q[$], eline_q[$];
    int in_cnt = 0, out_cnt = 0;
    int l_en, l_left, l_top, l_w, l_h;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = (ready_mode == 0) ? 1'b1 :
                          (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (s_if.tvalid && s_if.tready) begin
            if (err_sof)  esof_q.push_back(in_cnt);
            if (err_line) eline_q.push_back(in_cnt);
            in_cnt++;
        end else begin
            if (err_sof)  esof_q.push_back(-1);
            if (err_line) eline_q.push_back(-1);
        end
        if (m_if.tvalid && m_if.tready) begin
            out_q.push_back({s1_enable, m_if.tlast, m_if.tuser[TUSER_NEED],
                             m_if.tuser[TUSER_SOF], m_if.tdata});
            if (frame_done) fd_q.push_back(out_cnt);
            out_cnt++;
        end else if (frame_done) begin
            fd_q.push_back(-1);
        end
    end

    function automatic logic [11:0] exp_beat(input int r, input int c, input bit sof, input bit last);
        bit need;
        bit s1;
        logic [7:0] d;
        need = (l_en != 0) && r >= l_top && r < l_top + l_h && c >= l_left && c < l_left + l_w;
        s1   = (l_en != 0) && l_w != 0 && l_h != 0;
        d    = 8'(r * 16 + c);
        return {s1, last, need, sof, d};
    endfunction

    task automatic set_cfg(input int w, input int h, input bit en, input int lf, input int tp,
                           input int ww, input int wh);
        img_width = 12'(w); img_height = 12'(h); win_en = en;
        win_left = 12'(lf); win_top = 12'(tp); win_width = 12'(ww); win_height = 12'(wh);
    endtask

    task automatic send_px(input int r, input int c, input bit sof, input bit last, input bit fwd);
        int n;
        n = 0;
        if (rnd_valid) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if (sof) begin
            l_en = int'(win_en); l_left = int'(win_left); l_top = int'(win_top);
            l_w = int'(win_width); l_h = int'(win_height);
        end
        if (fwd) exp_q.push_back(exp_beat(r, c, sof, last));
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'(r * 16 + c);
        s_if.tuser  = sof;
        s_if.tlast  = last;
        forever begin
            @(negedge clk);
            if (s_if.tready) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $error("FAIL accept_timeout: observed=stalled expected=accepted");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input int w, input int nrows, input int short_row,
                              input int short_len, input bit chg);
        int n;
        for (int r = 0; r < nrows; r++) begin
            n = (r == short_row) ? short_len : w;
            for (int c = 0; c < n; c++) begin
                send_px(r, c, (r == 0 && c == 0), (c == n - 1), 1'b1);
                if (chg && r == 0 && c == 0) begin
                    win_left = 12'd0; win_top = 12'd0; win_width = 12'd2; win_height = 12'd1;
                end
            end
        end
    endtask

    task automatic drain();
        ready_mode = 0;
        repeat (12) begin @(posedge clk); #1; end
    endtask

    task automatic clear_mon();
        exp_q.delete(); out_q.delete(); fd_q.delete(); esof_q.delete(); eline_q.delete();
        in_cnt = 0; out_cnt = 0;
    endtask

    function automatic int need_count();
        int n;
        n = 0;
        foreach (out_q[i]) if (out_q[i][9]) n++;
        return n;
    endfunction

    task automatic check_stream(input string tag, input int n_exp);
        chk({tag, "_count"}, out_q.size(), n_exp);
        chk({tag, "_model_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_tvalid"}, m_if.tvalid, 0);
        chk({tag, "_m_tdata"},  m_if.tdata, 0);
        chk({tag, "_m_tuser"},  m_if.tuser, 0);
        chk({tag, "_m_tlast"},  m_if.tlast, 0);
        chk({tag, "_s_tready"}, s_if.tready, 0);
        chk({tag, "_s1_enable"}, s1_enable, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_err_sof"},  err_sof, 0);
        chk({tag, "_err_line"}, err_line, 0);
    endtask

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] beat;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
        set_cfg(10, 8, 1, 3, 2, 3, 4);
        resetn = 1'b0;
        #12;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_ready_release_cycle", s_if.tready, 0);
        @(posedge clk); #1;
        chk("rst_ready_next_cycle", s_if.tready, 1);
        clear_mon();

        // Dropped pre-SOF beats, then a clean 10x8 frame
        for (int i = 0; i < 5; i++) send_px(15, i, 1'b0, 1'b0, 1'b0);
        send_frame(10, 8, -1, 0, 1'b0);
        drain();
        check_stream("A", 80);
        chk("A_need", need_count(), 12);
        chk("A_fd_n", fd_q.size(), 1);
        chk("A_fd_at", fd_q.size() > 0 ? fd_q[0] : -1, 79);
        chk("A_esof_n", esof_q.size(), 0);
        chk("A_eline_n", eline_q.size(), 0);
        chk("A_s1_enable", s1_enable, 1);
        clear_mon();

        // Same frame with random valid/ready
        rnd_valid = 1; ready_mode = 1;
        send_frame(10, 8, -1, 0, 1'b0);
        rnd_valid = 0;
        drain();
        check_stream("B", 80);
        chk("B_need", need_count(), 12);
        chk("B_fd_at", fd_q.size() == 1 ? fd_q[0] : -1, 79);
        clear_mon();

        // Zero-width window, then window disabled
        set_cfg(10, 8, 1, 3, 2, 0, 4);
        send_frame(10, 8, -1, 0, 1'b0);
        drain();
        check_stream("C1", 80);
        chk("C1_need", need_count(), 0);
        chk("C1_s1_enable", s1_enable, 0);
        clear_mon();
        set_cfg(10, 8, 0, 3, 2, 3, 4);
        send_frame(10, 8, -1, 0, 1'b0);
        drain();
        check_stream("C2", 80);
        chk("C2_need", need_count(), 0);
        chk("C2_s1_enable", s1_enable, 0);
        clear_mon();

        // Window past the right edge; config changed after SOF applies next frame
        set_cfg(10, 8, 1, 8, 0, 5, 8);
        send_frame(10, 8, -1, 0, 1'b1);
        drain();
        check_stream("D", 80);
        chk("D_need", need_count(), 16);
        clear_mon();
        send_frame(10, 8, -1, 0, 1'b0);
        drain();
        check_stream("D2", 80);
        chk("D2_need", need_count(), 2);
        chk("D2_s1_enable", s1_enable, 1);
        clear_mon();

        // SOF injected at row 3
        set_cfg(10, 8, 1, 3, 2, 3, 4);
        send_frame(10, 3, -1, 0, 1'b0);
        send_frame(10, 8, -1, 0, 1'b0);
        drain();
        check_stream("E", 110);
        chk("E_esof_n", esof_q.size(), 1);
        chk("E_esof_at", esof_q.size() > 0 ? esof_q[0] : -1, 30);
        chk("E_eline_n", eline_q.size(), 0);
        chk("E_fd_n", fd_q.size(), 1);
        chk("E_fd_at", fd_q.size() > 0 ? fd_q[0] : -1, 109);
        clear_mon();

        // Short line: tlast at col 6 of width 10 on row 1
        send_frame(10, 8, 1, 7, 1'b0);
        drain();
        check_stream("F", 77);
        chk("F_eline_n", eline_q.size(), 1);
        chk("F_eline_at", eline_q.size() > 0 ? eline_q[0] : -1, 16);
        chk("F_esof_n", esof_q.size(), 0);
        chk("F_fd_at", fd_q.size() == 1 ? fd_q[0] : -1, 76);
        beat = out_q.size() > 17 ? out_q[17] : 12'hfff;
        chk("F_next_row_col0", beat[7:0], 8'h20);
        clear_mon();

        // Reset asserted mid-frame with a full buffer
        ready_mode = 2;
        @(posedge clk); #1;
        s_if.tvalid = 1'b1; s_if.tdata = 8'hA5; s_if.tuser = 1'b1; s_if.tlast = 1'b0;
        @(posedge clk); #1;
        s_if.tdata = 8'h5A; s_if.tuser = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("G_pre_tvalid", m_if.tvalid, 1);
        chk("G_pre_tdata", m_if.tdata, 8'hA5);
        chk("G_pre_s1_enable", s1_enable, 1);
        chk("G_pre_s_tready", s_if.tready, 0);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("G_rst");
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        ready_mode = 0;
        repeat (2) begin @(posedge clk); #1; end
        clear_mon();
        for (int i = 0; i < 3; i++) send_px(15, i, 1'b0, 1'b0, 1'b0);
        send_frame(10, 8, -1, 0, 1'b0);
        drain();
        check_stream("G", 80);
        chk("G_fd_at", fd_q.size() == 1 ? fd_q[0] : -1, 79);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
